// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo: PS/2 keyboard receiver feeding a small scan-code FIFO read by the CPU.
//
// Frames arriving on ps2_clk/ps2_data are synchronised, deserialised (start, 8 data bits
// LSB-first, odd parity, stop) and, if well formed, pushed into a DEPTH-entry byte FIFO.
// The CPU sees the FIFO head on key_data and pops one entry per rising edge of read_key.
//
// Ports:
//   clk        system clock
//   clrn       asynchronous active-low reset
//   ps2_clk    PS/2 clock pin (asynchronous)
//   ps2_data   PS/2 data pin (asynchronous)
//   read_key   level, high while the CPU addresses the key region
//   key_data   {23'h0, valid, byte} of the FIFO head, 0 when empty
//   ready      FIFO non-empty
//   overflow   sticky: a good frame was dropped because the FIFO was full
//   frame_err  one-cycle pulse per rejected or timed-out frame

module ps2_key_fifo #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        read_key,
  output logic [31:0] key_data,
  output logic        ready,
  output logic        overflow,
  output logic        frame_err
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [AW:0]   Full   = DEPTH[AW:0];
  localparam logic [AW:0]   CntOne = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrOne = AW'(1);
  localparam logic [TW-1:0] TmoOne = TW'(1);
  localparam logic [TW-1:0] TmoMax = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StParity,
    StStop,
    StCheck
  } state_e;

  // Synchronisers: bit 0 is the first stage, bit 2 the third.
  logic [2:0] ps2c_q;
  logic [2:0] ps2d_q;
  logic       fall;
  logic       rx_bit;

  state_e          state_q, state_d;
  logic [7:0]      sr_q, sr_d;
  logic [3:0]      bitcnt_q, bitcnt_d;
  logic            par_q, par_d;
  logic            stop_q, stop_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            frame_good;
  logic            frame_bad;

  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic            prev_read_q;
  logic            overflow_q, overflow_d;
  logic            frame_err_q;

  logic            pop;
  logic            push_ok;
  logic            drop;

  // Falling edge of the synced PS/2 clock; data is taken from the fully synced stage,
  // which the keyboard holds stable well around the clock edge.
  assign fall   = ps2c_q[2] & ~ps2c_q[1];
  assign rx_bit = ps2d_q[2];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ps2c_q <= '0;
      ps2d_q <= '0;
    end else begin
      ps2c_q <= {ps2c_q[1:0], ps2_clk};
      ps2d_q <= {ps2d_q[1:0], ps2_data};
    end
  end

  // Receiver next-state.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bitcnt_d   = bitcnt_q;
    par_d      = par_q;
    stop_d     = stop_q;
    tmo_d      = '0;
    frame_good = 1'b0;
    frame_bad  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (fall && !rx_bit) begin
          state_d  = StRecv;
          bitcnt_d = '0;
        end
      end
      StRecv: begin
        if (fall) begin
          sr_d     = {rx_bit, sr_q[7:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) state_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          par_d   = rx_bit;
          state_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          stop_d  = rx_bit;
          state_d = StCheck;
        end
      end
      StCheck: begin
        state_d = StIdle;
        // Odd parity over data + parity bit, and the stop bit must be high.
        if (stop_q && ^{sr_q, par_q}) frame_good = 1'b1;
        else                          frame_bad  = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Mid-frame watchdog: a stalled keyboard must not wedge the receiver.
    if (state_q == StRecv || state_q == StParity || state_q == StStop) begin
      if (fall) begin
        tmo_d = '0;
      end else if (tmo_q == TmoMax) begin
        tmo_d     = '0;
        state_d   = StIdle;
        frame_bad = 1'b1;
      end else begin
        tmo_d = tmo_q + TmoOne;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= StIdle;
      sr_q     <= '0;
      bitcnt_q <= '0;
      par_q    <= 1'b0;
      stop_q   <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      par_q    <= par_d;
      stop_q   <= stop_d;
      tmo_q    <= tmo_d;
    end
  end

  // FIFO control. A pop in the same cycle frees a slot, so a push into a full FIFO
  // is still accepted when the CPU reads at that moment.
  always_comb begin
    pop        = read_key & ~prev_read_q & (count_q != '0);
    push_ok    = frame_good & ((count_q != Full) | pop);
    drop       = frame_good & (count_q == Full) & ~pop;
    overflow_d = overflow_q | drop;
    wptr_d     = push_ok ? wptr_q + PtrOne : wptr_q;
    rptr_d     = pop ? rptr_q + PtrOne : rptr_q;
    count_d    = count_q;
    if (push_ok && !pop)      count_d = count_q + CntOne;
    else if (!push_ok && pop) count_d = count_q - CntOne;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      prev_read_q <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      prev_read_q <= read_key;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_bad;
    end
  end

  // Storage needs no reset: key_data is gated by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= sr_q;
  end

  always_comb begin
    key_data = '0;
    if (count_q != '0) key_data = {23'h0, 1'b1, mem_q[rptr_q]};
  end

  assign ready     = (count_q != '0);
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule
